// File: rtl/motor_pkg.sv
// Shared definitions for the N-phase motor commutator.
// Holds the FSM state encodings, the step-index width helper and the default
// timing constants shared with the motor clock generator.
package motor_pkg;

    // FSM encodings; these values appear directly on the state output.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam int DEFAULT_DEAD_CYC = 10;
    localparam int DEFAULT_PRESCALE = 100;

    // Bits needed for a step index running 0..2*phases-1.
    function automatic int step_w(input int phases);
        return $clog2(2 * phases);
    endfunction

endpackage

// File: rtl/motor_nphase_commutator_if.sv
// Control/status bundle between the configuration logic and the commutator.
//   run, dir, period, fault : commands from the controller (master -> slave)
//   hs, ls                  : per-leg high/low-side gate enables
//   stepIdx, stepPulse      : current step and its one-clock change strobe
//   state                   : 0 IDLE, 1 ALIGN, 2 RUN, 3 FAULT
interface motor_nphase_commutator_if #(
    parameter int PHASES = 3,
    parameter int PER_W  = 10
);
    localparam int STEP_W = motor_pkg::step_w(PHASES);

    logic              run;
    logic              dir;
    logic [PER_W-1:0]  period;
    logic              fault;
    logic [PHASES-1:0] hs;
    logic [PHASES-1:0] ls;
    logic [STEP_W-1:0] stepIdx;
    logic              stepPulse;
    logic [1:0]        state;

    modport master (
        output run, dir, period, fault,
        input  hs, ls, stepIdx, stepPulse, state
    );

    modport slave (
        input  run, dir, period, fault,
        output hs, ls, stepIdx, stepPulse, state
    );
endinterface

// File: rtl/motor_deadtime_leg.sv
// Dead-time gate driver for one half-bridge leg.
//   clk, nRst : clock and asynchronous active-low reset
//   enable    : leg may drive; 0 forces both switches off on the next edge
//   wantHigh  : 1 = high side wanted, 0 = low side wanted
//   hs, ls    : registered gate enables, never both high
// When the wanted switch changes the on-switch drops at the next edge and the
// new one rises DEAD_CYC+1 clocks after the change. Enabling the leg behaves
// like a change, so the first switch-on also waits DEAD_CYC+1 clocks.
module motor_deadtime_leg #(
    parameter int DEAD_CYC = 10
) (
    input  logic clk,
    input  logic nRst,
    input  logic enable,
    input  logic wantHigh,
    output logic hs,
    output logic ls
);
    localparam int CW = $clog2(DEAD_CYC + 2);

    logic [CW-1:0] cnt_q;
    logic          want_q;

    // cnt_q holds the off-cycles still owed; switching happens once it is <= 1.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hs     <= 1'b0;
            ls     <= 1'b0;
            cnt_q  <= '0;
            want_q <= 1'b0;
        end else if (!enable) begin
            hs     <= 1'b0;
            ls     <= 1'b0;
            // One extra count because the first enabled cycle is not a change.
            cnt_q  <= CW'(DEAD_CYC + 1);
            want_q <= wantHigh;
        end else if (wantHigh != want_q) begin
            // New request, or a revert mid dead-time: restart the dead period.
            hs     <= 1'b0;
            ls     <= 1'b0;
            cnt_q  <= CW'(DEAD_CYC);
            want_q <= wantHigh;
        end else if (cnt_q > CW'(1)) begin
            cnt_q <= cnt_q - CW'(1);
        end else begin
            cnt_q <= '0;
            hs    <= wantHigh;
            ls    <= !wantHigh;
        end
    end
endmodule

// File: rtl/motor_nphase_commutator.sv
// N-phase 180-degree step commutator with dead time, direction control,
// an align phase before running, and latched fault shutdown.
//   clk, nRst : motor clock and asynchronous active-low reset
//   bus       : slave side of the control/status bundle
//               (run, dir, period, fault in; hs, ls, stepIdx, stepPulse, state out)
// Contains the tick prescaler, shared tick counter (align length / step
// length), step index, FSM and per-leg wanted-level decode.
module motor_nphase_commutator
    import motor_pkg::*;
#(
    parameter int PHASES      = 3,
    parameter int PER_W       = 10,
    parameter int PRESCALE    = DEFAULT_PRESCALE,
    parameter int DEAD_CYC    = DEFAULT_DEAD_CYC,
    parameter int ALIGN_TICKS = 1000
) (
    input logic                     clk,
    input logic                     nRst,
    motor_nphase_commutator_if.slave bus
);
    localparam int STEP_W = step_w(PHASES);
    localparam int STEPS  = 2 * PHASES;
    localparam int PRE_W  = $clog2(PRESCALE);
    localparam int ALN_W  = $clog2(ALIGN_TICKS + 1);
    localparam int CNT_W  = (PER_W > ALN_W) ? PER_W : ALN_W;

    logic [1:0]        state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [STEP_W-1:0] step_q, step_d, step_nxt;
    logic [PER_W-1:0]  per_q, per_d;
    logic              pulse_q, pulse_d;
    logic              active, tick, leg_en;
    logic [PHASES-1:0] want_high, hs_w, ls_w;

    assign active = (state_q == ST_ALIGN) || (state_q == ST_RUN);
    assign tick   = active && (pre_q == PRE_W'(PRESCALE - 1));
    // Legs are cut on the same edge that stop or fault leaves ALIGN/RUN.
    assign leg_en = active && bus.run && !bus.fault;

    always_comb begin
        if (bus.dir) begin
            step_nxt = (step_q == '0) ? STEP_W'(STEPS - 1) : step_q - STEP_W'(1);
        end else begin
            step_nxt = (step_q == STEP_W'(STEPS - 1)) ? '0 : step_q + STEP_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tcnt_d  = tcnt_q;
        step_d  = step_q;
        per_d   = per_q;
        pulse_d = 1'b0;

        if (active) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.run && !bus.fault) begin
                    state_d = ST_ALIGN;
                    step_d  = '0;
                    pre_d   = '0;
                    tcnt_d  = '0;
                end
            end
            ST_ALIGN: begin
                if (tick) begin
                    if (tcnt_q == CNT_W'(ALIGN_TICKS - 1)) begin
                        state_d = ST_RUN;
                        tcnt_d  = '0;
                        per_d   = bus.period;
                    end else begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (per_q == '0) begin
                        // Held: keep polling period until it becomes non-zero.
                        per_d = bus.period;
                    end else if (tcnt_q == CNT_W'(per_q) - CNT_W'(1)) begin
                        tcnt_d  = '0;
                        step_d  = step_nxt;
                        per_d   = bus.period;
                        pulse_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                if (!bus.run && !bus.fault) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stop and fault override any step taken in the same cycle.
        if (active && !bus.run) begin
            state_d = ST_IDLE;
            step_d  = step_q;
            pulse_d = 1'b0;
        end
        if (bus.fault) begin
            state_d = ST_FAULT;
            step_d  = step_q;
            pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            tcnt_q  <= '0;
            step_q  <= '0;
            per_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tcnt_q  <= tcnt_d;
            step_q  <= step_d;
            per_q   <= per_d;
            pulse_q <= pulse_d;
        end
    end

    // Leg i is offset by 2i steps: high side while (step - 2i) mod 2N < N.
    always_comb begin
        want_high = '0;
        for (int i = 0; i < PHASES; i++) begin
            want_high[i] = ((int'(step_q) + STEPS - 2 * i) % STEPS) < PHASES;
        end
    end

    for (genvar g = 0; g < PHASES; g++) begin : g_leg
        motor_deadtime_leg #(
            .DEAD_CYC(DEAD_CYC)
        ) u_leg (
            .clk     (clk),
            .nRst    (nRst),
            .enable  (leg_en),
            .wantHigh(want_high[g]),
            .hs      (hs_w[g]),
            .ls      (ls_w[g])
        );
    end

    assign bus.hs        = hs_w;
    assign bus.ls        = ls_w;
    assign bus.stepIdx   = step_q;
    assign bus.stepPulse = pulse_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_motor_nphase_commutator.sv
// Bench for motor_nphase_commutator with PHASES=3, PRESCALE=4, DEAD_CYC=3,
// ALIGN_TICKS=8, PER_W=10. Step expectations are queued as stimulus is
// applied and popped by a monitor on each stepPulse.
module tb_motor_nphase_commutator;
    localparam int PHASES = 3;
    localparam int PER_W  = 10;

    logic clk;
    logic nRst;

    motor_nphase_commutator_if #(.PHASES(PHASES), .PER_W(PER_W)) bus ();

    motor_nphase_commutator #(
        .PHASES     (PHASES),
        .PER_W      (PER_W),
        .PRESCALE   (4),
        .DEAD_CYC   (3),
        .ALIGN_TICKS(8)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // 180-degree pattern per step, bit i = leg i.
    logic [2:0] hs_tab [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
    logic [2:0] ls_tab [6] = '{3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};

    typedef struct {
        int idx;
        int gap;   // clocks since previous pulse / RUN entry; -1 = don't care
    } exp_t;
    exp_t sbq[$];

    int cyc       = 0;
    int pulse_cnt = 0;
    int ref_cyc   = 0;
    int pulse_cyc = 0;
    int prev_idx  = 0;
    int last_idx  = 0;
    int last_state = 0;

    // Monitor: samples 1 time unit after each rising edge.
    always begin : mon
        int   k;
        int   cur;
        exp_t e;
        logic [2:0] eh, el;
        @(posedge clk);
        #1;
        cyc++;
        if (!nRst) begin
            last_state = 0;
            last_idx   = 0;
        end else begin
            check("no_shoot_through", int'(bus.hs & bus.ls), 0);
            if (int'(bus.state) == 2 && last_state != 2) begin
                ref_cyc   = cyc;
                pulse_cyc = cyc - 100;
            end
            if (bus.stepPulse) begin
                pulse_cnt++;
                check("pulse_expected", int'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("step_idx", int'(bus.stepIdx), e.idx);
                    if (e.gap >= 0) check("step_gap", cyc - ref_cyc, e.gap);
                end
                ref_cyc   = cyc;
                pulse_cyc = cyc;
                prev_idx  = last_idx;
            end
            if (int'(bus.state) == 2) begin
                k   = cyc - pulse_cyc;
                cur = int'(bus.stepIdx);
                if (k == 0) begin
                    eh = hs_tab[prev_idx];
                    el = ls_tab[prev_idx];
                end else if (k <= 3) begin
                    eh = hs_tab[prev_idx] & hs_tab[cur];
                    el = ls_tab[prev_idx] & ls_tab[cur];
                end else begin
                    eh = hs_tab[cur];
                    el = ls_tab[cur];
                end
                check("run_hs", int'(bus.hs), int'(eh));
                check("run_ls", int'(bus.ls), int'(el));
            end
            last_state = int'(bus.state);
            last_idx   = int'(bus.stepIdx);
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input int val, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step_clk();
            n++;
            if (int'(bus.state) == val) return;
        end
        check("wait_state_timeout", int'(bus.state), val);
    endtask

    task automatic wait_pulse(input int budget);
        int target;
        target = pulse_cnt + 1;
        for (int i = 0; i < budget; i++) begin
            step_clk();
            if (pulse_cnt >= target) return;
        end
        check("pulse_timeout", pulse_cnt, target);
    endtask

    typedef struct {
        bit dir;
        int period;
        int idx;
        int gap;
    } vec_t;
    vec_t vec[9];

    initial begin : main
        int n;
        int pc;

        // Inputs applied mid-step; they take effect at the next boundary.
        vec[0] = '{1'b0, 5, 1, 20};
        vec[1] = '{1'b0, 5, 2, 20};
        vec[2] = '{1'b0, 5, 3, 20};
        vec[3] = '{1'b1, 5, 2, 20};
        vec[4] = '{1'b1, 2, 1, 20};
        vec[5] = '{1'b1, 2, 0, 8};
        vec[6] = '{1'b1, 2, 5, 8};
        vec[7] = '{1'b0, 2, 0, 8};
        vec[8] = '{1'b0, 0, 1, 8};

        bus.run    = 1'b0;
        bus.dir    = 1'b0;
        bus.period = PER_W'(5);
        bus.fault  = 1'b0;
        nRst       = 1'b0;
        repeat (3) step_clk();
        check("rst_hs", int'(bus.hs), 0);
        check("rst_ls", int'(bus.ls), 0);
        check("rst_step", int'(bus.stepIdx), 0);
        check("rst_pulse", int'(bus.stepPulse), 0);
        check("rst_state", int'(bus.state), 0);

        nRst = 1'b1;
        step_clk();
        bus.run = 1'b1;
        wait_state(1, 10, n);
        check("align_entry_lat", n, 1);
        check("align_step0", int'(bus.stepIdx), 0);
        repeat (3) step_clk();
        check("align_dead_hs", int'(bus.hs), 0);
        check("align_dead_ls", int'(bus.ls), 0);
        step_clk();
        check("align_on_hs", int'(bus.hs), 5);
        check("align_on_ls", int'(bus.ls), 2);
        wait_state(2, 100, n);
        check("align_len", n + 4, 32);

        for (int k = 0; k < 9; k++) begin
            repeat (5) step_clk();
            bus.dir    = vec[k].dir;
            bus.period = PER_W'(vec[k].period);
            sbq.push_back('{vec[k].idx, vec[k].gap});
            wait_pulse(100);
        end

        // period latched as 0: frozen.
        pc = pulse_cnt;
        repeat (200) step_clk();
        check("freeze_idx", int'(bus.stepIdx), 1);
        check("freeze_pulses", pulse_cnt - pc, 0);

        bus.period = PER_W'(3);
        sbq.push_back('{2, -1});
        sbq.push_back('{3, 12});
        sbq.push_back('{4, 12});
        repeat (3) wait_pulse(100);

        // One-cycle fault in the middle of a dead time.
        repeat (2) step_clk();
        bus.fault = 1'b1;
        step_clk();
        check("fault_hs", int'(bus.hs), 0);
        check("fault_ls", int'(bus.ls), 0);
        check("fault_state", int'(bus.state), 3);
        bus.fault = 1'b0;
        repeat (10) step_clk();
        check("fault_latched", int'(bus.state), 3);
        bus.run = 1'b0;
        step_clk();
        check("fault_to_idle", int'(bus.state), 0);
        bus.period = PER_W'(5);
        bus.run    = 1'b1;
        step_clk();
        check("restart_align", int'(bus.state), 1);
        check("restart_step0", int'(bus.stepIdx), 0);

        sbq.push_back('{1, 20});
        wait_state(2, 100, n);
        wait_pulse(100);
        repeat (2) step_clk();
        check("pre_reset_on", int'((bus.hs | bus.ls) != 0), 1);
        #1;
        nRst = 1'b0;
        #1;
        check("async_rst_hs", int'(bus.hs), 0);
        check("async_rst_ls", int'(bus.ls), 0);
        check("async_rst_state", int'(bus.state), 0);
        check("async_rst_step", int'(bus.stepIdx), 0);
        repeat (2) step_clk();
        nRst = 1'b1;
        wait_state(1, 10, n);
        check("rst_restart_lat", n, 1);
        repeat (3) step_clk();
        check("rst_dead_hs", int'(bus.hs), 0);
        check("rst_dead_ls", int'(bus.ls), 0);
        step_clk();
        check("rst_on_hs", int'(bus.hs), 5);
        check("rst_on_ls", int'(bus.ls), 2);

        check("queue_drained", sbq.size(), 0);
        bus.run = 1'b0;
        repeat (2) step_clk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
